// File: rtl/frame_fifo_bridge_if.sv
// Stream bundle for the frame FIFO bridge: RX beats in, TX beats out.
// The master drives RX beats and TX ready; the slave is the bridge itself.
interface frame_fifo_bridge_if #(
    parameter int unsigned DW = 8
) ();
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_err;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    modport master (
        output in_data, in_valid, in_last, in_err, out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, in_last, in_err, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/frame_fifo_bridge.sv
// Store-and-forward frame FIFO between a non-stallable MAC RX stream and a
// valid/ready MAC TX stream. Only complete, error-free frames of legal length
// become visible to the read side; everything else is rolled back. A pause
// request with watermark hysteresis gives upstream flow control.
module frame_fifo_bridge #(
    parameter int unsigned DW           = 8,
    parameter int unsigned AW           = 11,
    parameter int unsigned MIN_LEN      = 60,
    parameter int unsigned HI_WM        = 1536,
    parameter int unsigned LO_WM        = 512,
    parameter logic [15:0] PAUSE_QUANTA = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    frame_fifo_bridge_if.slave  bus,
    output logic                pause_req,
    output logic [15:0]         pause_val,
    output logic [AW:0]         fill_level,
    output logic [15:0]         frame_count,
    output logic [15:0]         drop_count
);

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_STORE = 2'd1;
    localparam logic [1:0] W_DROP  = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_SEND = 1'b1;

    // Each entry carries the beat data plus its last flag.
    logic [DW:0] mem [DEPTH];

    logic [1:0]    w_state_q, w_state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   commit_ptr_q, commit_ptr_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   len_inc;

    logic          r_state_q;
    logic [AW:0]   fetch_ptr_q;   // next RAM entry to load into the output register
    logic [AW:0]   rd_ptr_q;      // entries handed over to TX (space is freed here)
    logic [DW-1:0] out_data_q;
    logic          out_last_q;

    logic          pause_q;
    logic [15:0]   frame_cnt_q;
    logic [15:0]   drop_cnt_q;

    logic [AW:0]   fill;
    logic          full;
    logic          mem_we;
    logic          commit;
    logic          drop;
    logic          xfer;
    logic          xfer_last;
    logic          fetch;

    // Fill includes uncommitted beats and the beat sitting in the output register.
    assign fill = wr_ptr_q - rd_ptr_q;
    assign full = (fill == FULL_LVL);

    assign xfer      = (r_state_q == R_SEND) && bus.out_ready;
    assign xfer_last = xfer && out_last_q;
    // Only committed entries may be prefetched; refill whenever the register empties.
    assign fetch     = (fetch_ptr_q != commit_ptr_q) && ((r_state_q == R_IDLE) || bus.out_ready);

    // Write FSM next state: store, commit, roll back or discard RX beats.
    always_comb begin
        w_state_d    = w_state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        mem_we       = 1'b0;
        commit       = 1'b0;
        drop         = 1'b0;

        // Beat count including the current beat, saturating at the RAM depth.
        if (w_state_q == W_STORE) begin
            len_inc = (len_q == FULL_LVL) ? FULL_LVL : (len_q + PTR_ONE);
        end else begin
            len_inc = PTR_ONE;
        end

        if (bus.in_valid) begin
            if ((w_state_q == W_DROP) || full) begin
                // Discard; the partial frame stays counted until its last beat.
                if (bus.in_last) begin
                    drop      = 1'b1;
                    wr_ptr_d  = commit_ptr_q;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_DROP;
                end
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                len_d    = len_inc;
                if (bus.in_last) begin
                    w_state_d = W_IDLE;
                    if (!bus.in_err && (32'(len_inc) >= MIN_LEN)) begin
                        commit       = 1'b1;
                        commit_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        drop     = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                    end
                end else begin
                    w_state_d = W_STORE;
                end
            end
        end
    end

    // Write FSM and write-side pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q    <= W_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            len_q        <= '0;
        end else begin
            w_state_q    <= w_state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            len_q        <= len_d;
        end
    end

    // Frame storage; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= {bus.in_last, bus.in_data};
        end
    end

    // Read FSM with prefetch output register; holds the beat while TX stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q   <= R_IDLE;
            fetch_ptr_q <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (xfer) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (fetch) begin
                {out_last_q, out_data_q} <= mem[fetch_ptr_q[AW-1:0]];
                fetch_ptr_q              <= fetch_ptr_q + PTR_ONE;
                r_state_q                <= R_SEND;
            end else if (xfer) begin
                r_state_q <= R_IDLE;
            end
        end
    end

    // Committed-frame and dropped-frame counters, both saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            case ({commit, xfer_last})
                2'b10: begin
                    if (frame_cnt_q != 16'hFFFF) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                2'b01: begin
                    if (frame_cnt_q != 16'h0000) begin
                        frame_cnt_q <= frame_cnt_q - 16'd1;
                    end
                end
                default: ;
            endcase
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // Pause request with hysteresis between the two watermarks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_q <= 1'b0;
        end else if (32'(fill) >= HI_WM) begin
            pause_q <= 1'b1;
        end else if (32'(fill) <= LO_WM) begin
            pause_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = (r_state_q == R_SEND);

    assign pause_req   = pause_q;
    assign pause_val   = pause_q ? PAUSE_QUANTA : 16'h0000;
    assign fill_level  = fill;
    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_frame_fifo_bridge.sv
// Bench for frame_fifo_bridge: a frame-level queue model for the full-size
// instance plus a directed full/drop scenario on a small-depth instance.
module tb_frame_fifo_bridge;

    localparam int unsigned DW      = 8;
    localparam int unsigned AW      = 11;
    localparam int unsigned DEPTH   = 2 ** AW;
    localparam int unsigned MIN_LEN = 60;
    localparam int unsigned HI_WM   = 1536;
    localparam int unsigned LO_WM   = 512;
    localparam int unsigned S_AW    = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_fifo_bridge_if #(.DW(DW)) bus ();
    frame_fifo_bridge_if #(.DW(DW)) bus_s ();

    logic          pause_req;
    logic [15:0]   pause_val;
    logic [AW:0]   fill_level;
    logic [15:0]   frame_count;
    logic [15:0]   drop_count;
    logic          s_pause_req;
    logic [15:0]   s_pause_val;
    logic [S_AW:0] s_fill_level;
    logic [15:0]   s_frame_count;
    logic [15:0]   s_drop_count;

    frame_fifo_bridge #(
        .DW(DW), .AW(AW), .MIN_LEN(MIN_LEN), .HI_WM(HI_WM), .LO_WM(LO_WM),
        .PAUSE_QUANTA(16'hFFFF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .pause_req(pause_req), .pause_val(pause_val), .fill_level(fill_level),
        .frame_count(frame_count), .drop_count(drop_count)
    );

    frame_fifo_bridge #(
        .DW(DW), .AW(S_AW), .MIN_LEN(MIN_LEN), .HI_WM(48), .LO_WM(16),
        .PAUSE_QUANTA(16'hFFFF)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s),
        .pause_req(s_pause_req), .pause_val(s_pause_val), .fill_level(s_fill_level),
        .frame_count(s_frame_count), .drop_count(s_drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: committed beats awaiting TX, beats of the frame being received.
    logic [8:0] m_q[$];
    logic [8:0] m_part[$];
    bit         m_dropping;
    int         m_frames;
    int         m_drops;
    bit         m_pause;
    int         m_age;
    int         m_last_len;
    int         m_fill;
    bit         m_full;
    logic [8:0] m_head;
    int         n_out;

    // Compare DUT state after the last edge, then advance the model to the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_part.delete();
            m_dropping = 1'b0;
            m_frames   = 0;
            m_drops    = 0;
            m_pause    = 1'b0;
            m_age      = 1000;
            m_last_len = 0;
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_last", bus.out_last, 0);
            check("rst_out_data", bus.out_data, 0);
            check("rst_pause", {pause_req, pause_val}, 0);
            check("rst_fill", fill_level, 0);
            check("rst_counts", {frame_count, drop_count}, 0);
        end else begin
            m_fill = m_q.size() + m_part.size();
            m_full = (m_fill == DEPTH);
            check("fill_level", fill_level, m_fill);
            check("frame_count", frame_count, m_frames);
            check("drop_count", drop_count, m_drops);
            check("pause_req", pause_req, m_pause);
            check("pause_val", pause_val, m_pause ? 16'hFFFF : 16'h0);
            if (m_q.size() == 0) begin
                check("valid_uncommitted", bus.out_valid, 0);
            end else if (m_age >= 2 || m_q.size() > m_last_len) begin
                check("valid_latency", bus.out_valid, 1);
            end
            if (bus.out_valid && m_q.size() > 0) begin
                m_head = m_q[0];
                check("out_beat", {bus.out_last, bus.out_data}, m_head);
                if (bus.out_ready) begin
                    void'(m_q.pop_front());
                    n_out++;
                    if (m_head[8]) m_frames--;
                end
            end
            if (m_fill >= HI_WM) m_pause = 1'b1;
            else if (m_fill <= LO_WM) m_pause = 1'b0;
            if (m_age < 1000) m_age++;
            if (bus.in_valid) begin
                if (m_dropping || m_full) begin
                    if (bus.in_last) begin
                        m_drops++;
                        m_part.delete();
                        m_dropping = 1'b0;
                    end else begin
                        m_dropping = 1'b1;
                    end
                end else begin
                    m_part.push_back({bus.in_last, bus.in_data});
                    if (bus.in_last) begin
                        if (!bus.in_err && m_part.size() >= MIN_LEN) begin
                            foreach (m_part[i]) m_q.push_back(m_part[i]);
                            m_frames++;
                            m_last_len = m_part.size();
                            m_age      = 0;
                        end else begin
                            m_drops++;
                        end
                        m_part.delete();
                    end
                end
            end
        end
    end

    // Small-instance TX monitor: both frames carry 0..59, only one may come out.
    int s_cnt = 0;
    always @(negedge clk) begin
        if (rst_n && bus_s.out_valid && bus_s.out_ready) begin
            s_cnt++;
            check("t4_data", bus_s.out_data, 32'(s_cnt - 1) & 32'hFF);
            check("t4_last", bus_s.out_last, (s_cnt == 60) ? 1 : 0);
        end
    end

    // TX ready pattern for the main instance.
    int rdy_mode = 1;
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                2:       bus.out_ready = ($urandom_range(3) != 0);
                default: bus.out_ready = ($urandom_range(9) == 0);
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input bit sel, input bit v, input logic [7:0] d, input bit l,
                              input bit e);
        if (sel) begin
            bus_s.in_valid = v; bus_s.in_data = d; bus_s.in_last = l; bus_s.in_err = e;
        end else begin
            bus.in_valid = v; bus.in_data = d; bus.in_last = l; bus.in_err = e;
        end
    endtask

    // in_err is randomised on non-last beats, where it must be ignored.
    task automatic send_frame(input bit sel, input int len, input bit err, input int gap_pct,
                              input bit seq);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                drive_beat(sel, 1'b0, 8'h00, 1'b0, 1'b0);
                tick();
            end
            drive_beat(sel, 1'b1, seq ? 8'(i) : 8'($urandom), (i == len - 1),
                       (i == len - 1) ? err : 1'($urandom_range(1)));
            tick();
        end
        drive_beat(sel, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_beat(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive_beat(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((m_q.size() != 0 || m_part.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, fill_level, 0);
    endtask

    int base;

    initial begin
        bus_s.out_ready = 1'b0;
        drive_beat(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive_beat(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();

        // T1: one legal frame, streamed straight through.
        rdy_mode = 1;
        base = n_out;
        send_frame(1'b0, 60, 1'b0, 0, 1'b1);
        tick();
        tick();
        check("t1_valid_by_2", bus.out_valid, 1);
        check("t1_frame_count", frame_count, 1);
        wait_drain("t1_drain", 500);
        check("t1_beats", n_out - base, 60);
        check("t1_frame_count_end", frame_count, 0);

        // T2: runt frame dropped, following frame passes.
        do_reset();
        base = n_out;
        send_frame(1'b0, 59, 1'b0, 0, 1'b1);
        send_frame(1'b0, 64, 1'b0, 0, 1'b1);
        wait_drain("t2_drain", 500);
        check("t2_beats", n_out - base, 64);
        check("t2_drops", drop_count, 1);

        // T3: errored frame leaves nothing behind.
        do_reset();
        base = n_out;
        send_frame(1'b0, 70, 1'b1, 0, 1'b0);
        repeat (4) tick();
        check("t3_fill", fill_level, 0);
        check("t3_drops", drop_count, 1);
        check("t3_no_out", n_out - base, 0);

        // T4: small instance overflows on the second frame.
        do_reset();
        s_cnt = 0;
        send_frame(1'b1, 60, 1'b0, 0, 1'b1);
        send_frame(1'b1, 60, 1'b0, 0, 1'b1);
        repeat (3) tick();
        check("t4_drops", s_drop_count, 1);
        check("t4_frames", s_frame_count, 1);
        check("t4_fill", s_fill_level, 60);
        check("t4_pause", {s_pause_req, s_pause_val}, {1'b1, 16'hFFFF});
        bus_s.out_ready = 1'b1;
        repeat (100) tick();
        check("t4_beats", s_cnt, 60);
        check("t4_fill_end", s_fill_level, 0);
        check("t4_frames_end", s_frame_count, 0);
        check("t4_pause_end", s_pause_req, 0);
        bus_s.out_ready = 1'b0;

        // T5: fill to the high watermark, then drain through the hysteresis band.
        do_reset();
        rdy_mode = 0;
        repeat (6) send_frame(1'b0, 256, 1'b0, 0, 1'b0);
        tick();
        tick();
        check("t5_fill_hi", fill_level, 1536);
        check("t5_pause_on", {pause_req, pause_val}, {1'b1, 16'hFFFF});
        rdy_mode = 2;
        wait_drain("t5_drain", 10000);
        tick();
        check("t5_pause_off", {pause_req, pause_val}, 0);

        // T6: reset in the middle of a frame, then a clean frame.
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 30; i++) begin
            drive_beat(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            tick();
        end
        rst_n = 1'b0;
        drive_beat(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        base = n_out;
        send_frame(1'b0, 80, 1'b0, 0, 1'b0);
        wait_drain("t6_drain", 500);
        check("t6_beats", n_out - base, 80);
        check("t6_drops", drop_count, 0);

        // Random frames with random gaps, errors and TX back-pressure.
        do_reset();
        for (int f = 0; f < 40; f++) begin
            if (f % 8 == 0) rdy_mode = 1 + $urandom_range(2);
            send_frame(1'b0, 1 + $urandom_range(149), ($urandom_range(7) == 0), 20, 1'b0);
        end
        rdy_mode = 1;
        wait_drain("rand_drain", 10000);

        // Heavy back-pressure with long frames so some frames hit a full FIFO.
        rdy_mode = 3;
        for (int f = 0; f < 10; f++) begin
            send_frame(1'b0, 200 + $urandom_range(100), 1'b0, 0, 1'b0);
        end
        rdy_mode = 2;
        wait_drain("stress_drain", 20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: summary not reached, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule
